muldiv_unit: RTL

Iterative multiply/divide unit for the MIPS execute stage, sitting directly downstream of the register memory. It consumes the two register-read operands (rs, rt), computes MULT/MULTU/DIV/DIVU over multiple cycles, and holds the 64-bit result in architectural HI/LO registers. It exposes `busy` so the hazard logic can stall, and HI/LO outputs for MFHI/MFLO writeback into the register memory.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage types and helpers for the multiply/divide unit.
package mips_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } muldiv_state_t;

   localparam int unsigned MD_ITER = 32;

   // Magnitude of a two's-complement word; 0x8000_0000 maps to itself,
   // which is the correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] x);
      return ~x + 64'd1;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on capture, iterated for MD_ITER cycles
// (shift-add or restoring divide), then sign-corrected in FIX.
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  muldiv_op_t      op,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] rt_data,
   input  logic            mthi,
   input  logic            mtlo,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   muldiv_state_t state, state_next;

   logic [5:0]   cnt;
   logic [63:0]  acc;      // mult: product(hi half) | multiplier(lo half); div: remainder | dividend->quotient
   logic [31:0]  opnd;     // multiplicand or divisor magnitude
   logic         is_div;
   logic         neg_main; // product sign or quotient sign
   logic         neg_rem;  // remainder sign

   logic         op_signed;
   logic         div_zero;
   logic [31:0]  cap_rs;
   logic [31:0]  cap_rt;
   logic [32:0]  mul_sum;
   logic [32:0]  div_shift;
   logic [32:0]  div_diff;
   logic [63:0]  step_acc;
   logic [63:0]  prod;
   logic [31:0]  res_hi;
   logic [31:0]  res_lo;

   // Next-state selection; divide by zero bypasses the iteration entirely.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = div_zero ? FIX : RUN;
         RUN:  if (cnt == 6'(MD_ITER - 1)) state_next = FIX;
         FIX:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, one iteration step, and final sign correction.
   always_comb begin
      op_signed = ~op[0];
      div_zero  = op[1] && (rt_data == '0);
      cap_rs    = op_signed ? abs32(rs_data) : rs_data;
      cap_rt    = op_signed ? abs32(rt_data) : rt_data;

      mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
      div_shift = {acc[63:32], acc[31]};
      div_diff  = div_shift - {1'b0, opnd};

      if (is_div) begin
         if (div_diff[32]) step_acc = {div_shift[31:0], acc[30:0], 1'b0};
         else              step_acc = {div_diff[31:0],  acc[30:0], 1'b1};
      end else begin
         step_acc = {mul_sum, acc[31:1]};
      end

      prod = neg_main ? neg64(acc) : acc;
      if (is_div) begin
         res_lo = neg_main ? (~acc[31:0] + 32'd1)  : acc[31:0];
         res_hi = neg_rem  ? (~acc[63:32] + 32'd1) : acc[63:32];
      end else begin
         res_lo = prod[31:0];
         res_hi = prod[63:32];
      end
   end

   // Control FSM with registered busy/done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
         done  <= (state == FIX);
      end
   end

   // Datapath: capture, iterate, and HI/LO writes (moves only when idle without start).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         is_div   <= 1'b0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt    <= '0;
                  is_div <= op[1];
                  if (div_zero) begin
                     // Preload the final answer so FIX passes it through unchanged.
                     acc      <= {rs_data, 32'hFFFF_FFFF};
                     opnd     <= '0;
                     neg_main <= 1'b0;
                     neg_rem  <= 1'b0;
                  end else if (op[1]) begin
                     acc      <= {32'd0, cap_rs};
                     opnd     <= cap_rt;
                     neg_main <= op_signed & (rs_data[31] ^ rt_data[31]);
                     neg_rem  <= op_signed & rs_data[31];
                  end else begin
                     acc      <= {32'd0, cap_rt};
                     opnd     <= cap_rs;
                     neg_main <= op_signed & (rs_data[31] ^ rt_data[31]);
                     neg_rem  <= 1'b0;
                  end
               end else begin
                  if (mthi) hi <= rs_data;
                  if (mtlo) lo <= rs_data;
               end
            end
            RUN: begin
               acc <= step_acc;
               cnt <= cnt + 6'd1;
            end
            FIX: begin
               hi <= res_hi;
               lo <= res_lo;
            end
            default: ;
         endcase
      end
   end

endmodule
